// File: rtl/sd_slv_rdgen.sv
// rtl/sd_slv_rdgen.sv - SD slave read-data block framing sequencer (start/data/CRC/end/gap) with stop handling.
// SD_SLV_RDGEN_8BIT_EN enables 8-bit bus mode; without it bus_width 11 runs as 1-bit.
module sd_slv_rdgen #(
    parameter int AW      = 10,
    parameter int LW      = 10,
    parameter int BCW     = 8,
    parameter int GAP_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     bus_width,
    input  logic           start,
    input  logic [AW-1:0]  start_addr,
    input  logic [LW-1:0]  blk_len,
    input  logic [BCW-1:0] blk_cnt,
    input  logic           stop,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_en,
    output logic [2:0]     lane_sel,
    output logic           start_bit,
    output logic           data_en,
    output logic           crc_shift,
    output logic           end_bit,
    output logic           busy,
    output logic           done,
    output logic [BCW-1:0] blk_idx
);

    localparam int BW = LW + 3;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END, S_GAP} state_t;
    typedef enum logic [1:0] {M1 = 2'd0, M4 = 2'd1, M8 = 2'd2} mode_t;

    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [LW-1:0]  len_q, len_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic [BCW-1:0] idx_q, idx_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [2:0]     lane_q, lane_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [3:0]     crc_q, crc_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           pend_q, pend_d;
    logic           start_bit_q, data_en_q, mem_en_q, crc_shift_q, end_bit_q, busy_q, done_q;
    logic           done_d;
    logic [BCW-1:0] idx_inc;

    function automatic mode_t decode_mode(logic [1:0] bw);
        mode_t m;
        m = M1;
        if (bw == 2'b10) m = M4;
`ifdef SD_SLV_RDGEN_8BIT_EN
        if (bw == 2'b11) m = M8;
`endif
        return m;
    endfunction

    function automatic logic [2:0] top_lane(mode_t m);
        logic [2:0] l;
        case (m)
            M4:      l = 3'd1;
`ifdef SD_SLV_RDGEN_8BIT_EN
            M8:      l = 3'd0;
`endif
            default: l = 3'd7;
        endcase
        return l;
    endfunction

    // (len-1) wraps to 2^LW-1 for len==0, so the 2^LW-byte case needs no extra term.
    function automatic logic [BW-1:0] beats_m1(mode_t m, logic [LW-1:0] len);
        logic [LW-1:0] lm1;
        logic [BW-1:0] b;
        lm1 = len - LW'(1);
        case (m)
            M4:      b = BW'({lm1, 1'b1});
`ifdef SD_SLV_RDGEN_8BIT_EN
            M8:      b = BW'(lm1);
`endif
            default: b = {lm1, 3'b111};
        endcase
        return b;
    endfunction

    assign idx_inc = idx_q + BCW'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        crc_d   = crc_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    mode_d  = decode_mode(bus_width);
                    len_d   = blk_len;
                    cnt_d   = blk_cnt;
                    addr_d  = start_addr;
                    idx_d   = '0;
                end
            end
            S_START: begin
                pend_d  = pend_q | stop;
                state_d = S_DATA;
                beat_d  = beats_m1(mode_q, len_q);
                lane_d  = top_lane(mode_q);
            end
            S_DATA: begin
                pend_d = pend_q | stop;
                if (lane_q == 3'd0) begin
                    addr_d = addr_q + AW'(1);
                    lane_d = top_lane(mode_q);
                end else begin
                    lane_d = lane_q - 3'd1;
                end
                if (beat_q == '0) begin
                    state_d = S_CRC;
                    crc_d   = 4'd15;
                end else begin
                    beat_d = beat_q - BW'(1);
                end
            end
            S_CRC: begin
                pend_d = pend_q | stop;
                if (crc_q == 4'd0) state_d = S_END;
                else crc_d = crc_q - 4'd1;
            end
            S_END: begin
                idx_d = idx_inc;
                if (pend_q || stop || (cnt_q != '0 && idx_inc == cnt_q)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GW'(GAP_CYC - 1);
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == '0) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M1;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            lane_q      <= '0;
            beat_q      <= '0;
            crc_q       <= '0;
            gap_q       <= '0;
            pend_q      <= 1'b0;
            start_bit_q <= 1'b0;
            data_en_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            crc_shift_q <= 1'b0;
            end_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            crc_q       <= crc_d;
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            start_bit_q <= (state_d == S_START);
            data_en_q   <= (state_d == S_DATA);
            mem_en_q    <= (state_d == S_DATA) && (lane_d == top_lane(mode_q));
            crc_shift_q <= (state_d == S_CRC);
            end_bit_q   <= (state_d == S_END);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign lane_sel  = lane_q;
    assign blk_idx   = idx_q;
    assign mem_en    = mem_en_q;
    assign start_bit = start_bit_q;
    assign data_en   = data_en_q;
    assign crc_shift = crc_shift_q;
    assign end_bit   = end_bit_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
